// File: rtl/nn_pkg.sv
// Shared types and defaults for the sequential neuron MAC.
// Configuration macro: NN_MAC_SAT_EN (saturating adds + ovf flag when defined).
package nn_pkg;

  localparam int DEF_W_WIDTH   = 8;
  localparam int DEF_ACC_WIDTH = 16;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    BIAS,
    DONE
  } mac_state_e;

  // Width of the input index counter; at least one bit even for a single input.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/neuron_mac_seq_if.sv
// Operand/result handshake bundle between the MAC and its neighbours.
// master: upstream/downstream environment; slave: the MAC itself.
interface neuron_mac_seq_if
  import nn_pkg::*;
#(
  parameter int N_INPUTS  = 2,
  parameter int W_WIDTH   = DEF_W_WIDTH,
  parameter int ACC_WIDTH = DEF_ACC_WIDTH
);

  logic                         in_valid;
  logic                         in_ready;
  logic [N_INPUTS-1:0]          x;
  logic [N_INPUTS*W_WIDTH-1:0]  w;
  logic [W_WIDTH-1:0]           bias;
  logic                         out_valid;
  logic                         out_ready;
  logic [ACC_WIDTH-1:0]         h;
  logic                         ovf;

  modport master (
    output in_valid, x, w, bias, out_ready,
    input  in_ready, out_valid, h, ovf
  );

  modport slave (
    input  in_valid, x, w, bias, out_ready,
    output in_ready, out_valid, h, ovf
  );

endinterface

// File: rtl/nn_sat_add.sv
// Signed ACC_WIDTH adder shared by every accumulation step.
// Configuration macro: NN_MAC_SAT_EN -- when defined the sum clamps to the
// signed range and sat flags the clamp; otherwise the sum wraps and sat is 0.
module nn_sat_add #(
  parameter int ACC_WIDTH = 16
) (
  input  logic signed [ACC_WIDTH-1:0] a,
  input  logic signed [ACC_WIDTH-1:0] b,
  output logic signed [ACC_WIDTH-1:0] sum,
  output logic                        sat
);

`ifdef NN_MAC_SAT_EN
  logic signed [ACC_WIDTH:0] wide;

  // One guard bit exposes overflow; clamp toward the sign of the true result.
  always_comb begin
    wide = {a[ACC_WIDTH-1], a} + {b[ACC_WIDTH-1], b};
    sat  = wide[ACC_WIDTH] ^ wide[ACC_WIDTH-1];
    if (!sat) begin
      sum = wide[ACC_WIDTH-1:0];
    end else if (wide[ACC_WIDTH]) begin
      sum = {1'b1, {(ACC_WIDTH-1){1'b0}}};
    end else begin
      sum = {1'b0, {(ACC_WIDTH-1){1'b1}}};
    end
  end
`else
  assign sum = a + b;
  assign sat = 1'b0;
`endif

endmodule

// File: rtl/neuron_mac_seq.sv
// Sequential multiply-accumulate front end of a neuron: one binary input per
// cycle through a single shared adder, then the bias, then a held result.
// Configuration macro: NN_MAC_SAT_EN (saturating adds, sticky ovf per op).
module neuron_mac_seq
  import nn_pkg::*;
#(
  parameter int N_INPUTS  = 2,
  parameter int W_WIDTH   = DEF_W_WIDTH,
  parameter int ACC_WIDTH = DEF_ACC_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  neuron_mac_seq_if.slave  bus
);

  localparam int                   IDX_WIDTH = idx_width(N_INPUTS);
  localparam logic [IDX_WIDTH-1:0] LAST_IDX  = IDX_WIDTH'(N_INPUTS - 1);

  mac_state_e                  state;
  logic [N_INPUTS-1:0]         x_r;
  logic signed [W_WIDTH-1:0]   w_r [N_INPUTS];
  logic signed [W_WIDTH-1:0]   bias_r;
  logic signed [ACC_WIDTH-1:0] acc;
  logic [IDX_WIDTH-1:0]        idx;
  logic                        in_ready_r;
  logic                        out_valid_r;
  logic                        ovf_r;
  logic signed [ACC_WIDTH-1:0] h_r;
  logic signed [ACC_WIDTH-1:0] addend;
  logic signed [ACC_WIDTH-1:0] sum;
  logic                        sat;
  logic                        accept;

  assign accept = in_ready_r && bus.in_valid;

  // Select the term added this cycle: gated weight in ACCUM, bias in BIAS.
  always_comb begin
    // NOTE: default first so every path assigns addend and no latch is inferred.
    addend = '0;
    case (state)
      ACCUM:   if (x_r[idx]) addend = ACC_WIDTH'(w_r[idx]);
      BIAS:    addend = ACC_WIDTH'(bias_r);
      default: addend = '0;
    endcase
  end

  nn_sat_add #(
    .ACC_WIDTH (ACC_WIDTH)
  ) u_add (
    .a   (acc),
    .b   (addend),
    .sum (sum),
    .sat (sat)
  );

  // Operand capture on accept; later changes on the bus are ignored.
  always_ff @(posedge clk) begin
    // NOTE: operand registers are always written before use, so they carry no reset.
    if (!rst && accept) begin
      x_r    <= bus.x;
      bias_r <= bus.bias;
      for (int i = 0; i < N_INPUTS; i++) begin
        w_r[i] <= bus.w[i*W_WIDTH +: W_WIDTH];
      end
    end
  end

  // Control FSM with registered handshake outputs, result and overflow flag.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      state       <= IDLE;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      h_r         <= '0;
      ovf_r       <= 1'b0;
      acc         <= '0;
      idx         <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            acc        <= '0;
            idx        <= '0;
            ovf_r      <= 1'b0;
            in_ready_r <= 1'b0;
            state      <= ACCUM;
          end
        end
        ACCUM: begin
          acc   <= sum;
          ovf_r <= ovf_r | sat;
          if (idx == LAST_IDX) begin
            state <= BIAS;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        BIAS: begin
          acc         <= sum;
          h_r         <= sum;
          ovf_r       <= ovf_r | sat;
          out_valid_r <= 1'b1;
          state       <= DONE;
        end
        DONE: begin
          // No accept in the exit cycle: in_ready only rises once back in IDLE.
          if (bus.out_ready) begin
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_r;
  assign bus.out_valid = out_valid_r;
  assign bus.h         = h_r;
  assign bus.ovf       = ovf_r;

endmodule

// File: tb/tb_neuron_mac_seq.sv
// Self-checking bench for neuron_mac_seq: directed cases plus random
// operands compared against a plain-arithmetic reference model.
// Honours NN_MAC_SAT_EN when computing expected results.
module tb_neuron_mac_seq;

  logic clk;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  // Instance A: N=2, 16-bit accumulator; instance B: N=3, 8-bit accumulator.
  neuron_mac_seq_if #(.N_INPUTS(2), .W_WIDTH(8), .ACC_WIDTH(16)) bus_a ();
  neuron_mac_seq_if #(.N_INPUTS(3), .W_WIDTH(8), .ACC_WIDTH(8))  bus_b ();

  neuron_mac_seq #(.N_INPUTS(2), .W_WIDTH(8), .ACC_WIDTH(16)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (bus_a.slave)
  );

  neuron_mac_seq #(.N_INPUTS(3), .W_WIDTH(8), .ACC_WIDTH(8)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (bus_b.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input longint obs, input longint exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int n_of(input int sel);
    return (sel != 0) ? 3 : 2;
  endfunction

  function automatic int accw_of(input int sel);
    return (sel != 0) ? 8 : 16;
  endfunction

  function automatic logic get_ready(input int sel);
    return (sel != 0) ? bus_b.in_ready : bus_a.in_ready;
  endfunction

  function automatic logic get_valid(input int sel);
    return (sel != 0) ? bus_b.out_valid : bus_a.out_valid;
  endfunction

  function automatic logic get_ovf(input int sel);
    return (sel != 0) ? bus_b.ovf : bus_a.ovf;
  endfunction

  function automatic longint get_h(input int sel);
    if (sel != 0) return longint'($signed(bus_b.h));
    return longint'($signed(bus_a.h));
  endfunction

  task automatic drive(input int sel, input logic v, input logic [7:0] xv,
                       input logic [63:0] wv, input logic [7:0] bv);
    if (sel == 0) begin
      bus_a.in_valid = v;
      bus_a.x        = xv[1:0];
      bus_a.w        = wv[15:0];
      bus_a.bias     = bv;
    end else begin
      bus_b.in_valid = v;
      bus_b.x        = xv[2:0];
      bus_b.w        = wv[23:0];
      bus_b.bias     = bv;
    end
  endtask

  task automatic set_out_ready(input int sel, input logic v);
    if (sel == 0) bus_a.out_ready = v;
    else          bus_b.out_ready = v;
  endtask

  // Reference: ordered list of selected weights then bias, each add either
  // clamped to the signed range or wrapped modulo 2^accw.
  function automatic void model(input int n, input int accw, input logic [7:0] xv,
                                input logic [63:0] wv, input logic [7:0] bv,
                                output longint h, output bit ovf);
    longint terms[$];
    longint acc;
    longint lim;
    lim = longint'(1) <<< (accw - 1);
    acc = 0;
    ovf = 1'b0;
    for (int i = 0; i < n; i++) begin
      if (xv[i]) terms.push_back(longint'($signed(wv[i*8 +: 8])));
    end
    terms.push_back(longint'($signed(bv)));
    foreach (terms[k]) begin
      acc = acc + terms[k];
`ifdef NN_MAC_SAT_EN
      if (acc > lim - 1) begin
        acc = lim - 1;
        ovf = 1'b1;
      end else if (acc < -lim) begin
        acc = -lim;
        ovf = 1'b1;
      end
`else
      acc = acc % (2 * lim);
      if (acc >= lim)       acc = acc - 2 * lim;
      else if (acc < -lim)  acc = acc + 2 * lim;
`endif
    end
    h = acc;
  endfunction

  // One full operation with optional backpressure; checks latency, result,
  // hold behaviour and return to IDLE.
  task automatic run_op(input int sel, input logic [7:0] xv, input logic [63:0] wv,
                        input logic [7:0] bv, input int hold,
                        output longint got_h, output bit got_ovf);
    longint exp_h;
    bit     exp_ovf;
    longint held;
    int     n;
    int     lat;
    model(n_of(sel), accw_of(sel), xv, wv, bv, exp_h, exp_ovf);
    n = 0;
    while (!get_ready(sel) && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check("ready_before_op", longint'(get_ready(sel)), 1);
    set_out_ready(sel, (hold == 0));
    drive(sel, 1'b1, xv, wv, bv);
    @(posedge clk); #1;
    lat = 1;
    // Scramble operands after accept; they must be ignored.
    drive(sel, 1'b0, 8'($urandom), {$urandom, $urandom}, 8'($urandom));
    while (!get_valid(sel) && lat < 30) begin
      @(posedge clk); #1;
      lat++;
    end
    check("latency", lat, n_of(sel) + 2);
    got_h   = get_h(sel);
    got_ovf = get_ovf(sel);
    check("h", got_h, exp_h);
    check("ovf", longint'(got_ovf), longint'(exp_ovf));
    held = got_h;
    for (int k = 0; k < hold; k++) begin
      drive(sel, 1'b1, 8'($urandom), {$urandom, $urandom}, 8'($urandom));
      @(posedge clk); #1;
      check("bp_h_stable", get_h(sel), held);
      check("bp_valid", longint'(get_valid(sel)), 1);
      check("bp_in_ready", longint'(get_ready(sel)), 0);
    end
    drive(sel, 1'b0, 8'h00, 64'h0, 8'h00);
    set_out_ready(sel, 1'b1);
    @(posedge clk); #1;
    check("exit_valid", longint'(get_valid(sel)), 0);
    check("exit_in_ready", longint'(get_ready(sel)), 1);
  endtask

  initial begin
    longint      gh;
    bit          gov;
    logic [7:0]  rx;
    logic [63:0] rw;
    logic [7:0]  rb;
    longint      q[$];
    longint      eh;
    bit          eov;
    longint      pre_h;
    logic        pre_acc;
    logic        pre_out;
    int          last_acc;
    int          n_acc;
    int          n_out;

    rst = 1'b1;
    drive(0, 1'b0, 8'h00, 64'h0, 8'h00);
    drive(1, 1'b0, 8'h00, 64'h0, 8'h00);
    set_out_ready(0, 1'b1);
    set_out_ready(1, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    for (int s = 0; s < 2; s++) begin
      check("rst_in_ready", longint'(get_ready(s)), 1);
      check("rst_out_valid", longint'(get_valid(s)), 0);
      check("rst_h", get_h(s), 0);
      check("rst_ovf", longint'(get_ovf(s)), 0);
    end
    rst = 1'b0;
    @(posedge clk); #1;

    // AND gate: w0=w1=+20, bias=-30.
    run_op(0, 8'b11, 64'h1414, 8'hE2, 0, gh, gov);
    check("and_11", gh, 10);
    run_op(0, 8'b01, 64'h1414, 8'hE2, 0, gh, gov);
    check("and_01", gh, -10);
    run_op(0, 8'b00, 64'h1414, 8'hE2, 0, gh, gov);
    check("and_00", gh, -30);
    check("and_00_ovf", longint'(gov), 0);

    // Backpressure: out_ready low for 5 cycles with in_valid pushed.
    run_op(0, 8'b11, 64'h1414, 8'hE2, 5, gh, gov);
    check("bp_result", gh, 10);

    // 8-bit accumulator overflow: 127+127+127.
    run_op(1, 8'b011, 64'h007F7F, 8'h7F, 0, gh, gov);
`ifdef NN_MAC_SAT_EN
    check("acc8_h", gh, 127);
    check("acc8_ovf", longint'(gov), 1);
`else
    check("acc8_h", gh, 125);
    check("acc8_ovf", longint'(gov), 0);
`endif

    // Reset while accumulating abandons the op.
    set_out_ready(0, 1'b1);
    drive(0, 1'b1, 8'b11, 64'h3030, 8'h05);
    @(posedge clk); #1;
    drive(0, 1'b0, 8'h00, 64'h0, 8'h00);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("mid_rst_in_ready", longint'(get_ready(0)), 1);
    check("mid_rst_out_valid", longint'(get_valid(0)), 0);
    check("mid_rst_h", get_h(0), 0);
    run_op(0, 8'b10, 64'h9C14, 8'h03, 0, gh, gov);
    check("after_rst", gh, -97);

    // Random operands on both instances, occasional backpressure.
    for (int k = 0; k < 24; k++) begin
      rx = 8'($urandom);
      rw = {$urandom, $urandom};
      rb = 8'($urandom);
      run_op(k % 2, rx, rw, rb, int'($urandom_range(0, 2)), gh, gov);
    end

    // Back-to-back: in_valid held high, out_ready high.
    last_acc = -1;
    n_acc    = 0;
    n_out    = 0;
    rx = 8'($urandom);
    rw = {$urandom, $urandom};
    rb = 8'($urandom);
    set_out_ready(0, 1'b1);
    drive(0, 1'b1, rx, rw, rb);
    for (int cyc = 0; cyc < 80; cyc++) begin
      if (cyc == 60) bus_a.in_valid = 1'b0;
      pre_acc = bus_a.in_ready && bus_a.in_valid;
      pre_out = bus_a.out_valid && bus_a.out_ready;
      pre_h   = get_h(0);
      @(posedge clk); #1;
      if (pre_out) begin
        n_out++;
        if (q.size() == 0) check("b2b_extra_result", 1, 0);
        else               check("b2b_h", pre_h, q.pop_front());
      end
      if (pre_acc) begin
        model(2, 16, rx, rw, rb, eh, eov);
        q.push_back(eh);
        if (last_acc >= 0) check("b2b_interval", cyc - last_acc, 5);
        last_acc = cyc;
        n_acc++;
        rx = 8'($urandom);
        rw = {$urandom, $urandom};
        rb = 8'($urandom);
        drive(0, (cyc < 59), rx, rw, rb);
      end
    end
    check("b2b_accepts", n_acc, 12);
    check("b2b_results", n_out, n_acc);
    check("b2b_pending", q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
